// File: rtl/gs_ddram_pkg.sv
// Shared types and helpers for the GS-to-DDRAM byte bridge.
package gs_ddram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ
  } gs_st_t;

  localparam int GS_TAG_W = 18;

  function automatic logic [7:0] lane_be(input logic [2:0] lane);
    return 8'b0000_0001 << lane;
  endfunction

endpackage

// File: rtl/gs_line_cache.sv
// One-line (8-byte) read cache: holds line/tag/valid, compares tags and patches written bytes.
module gs_line_cache
  import gs_ddram_pkg::*;
(
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [GS_TAG_W-1:0] lookup_tag,
  input  logic [2:0]          lookup_lane,
  output logic                hit,
  output logic [7:0]          lookup_byte,
  input  logic                load_en,
  input  logic [63:0]         load_line,
  input  logic [GS_TAG_W-1:0] load_tag,
  input  logic                patch_en,
  input  logic [2:0]          patch_lane,
  input  logic [7:0]          patch_data
);

  logic [63:0]         line;
  logic [GS_TAG_W-1:0] tag;
  logic                valid;

  assign hit         = valid && (tag == lookup_tag);
  assign lookup_byte = line[{lookup_lane, 3'b000} +: 8];

  // A fill always wins over a patch; the controller never requests both at once.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      line  <= 64'd0;
      tag   <= '0;
      valid <= 1'b0;
    end else if (load_en) begin
      line  <= load_line;
      tag   <= load_tag;
      valid <= 1'b1;
    end else if (patch_en) begin
      line[{patch_lane, 3'b000} +: 8] <= patch_data;
    end
  end

endmodule

// File: rtl/gs_ddram_bridge.sv
// Byte-wide GS memory port onto the shared 64-bit DDRAM port, with a one-qword read cache.
module gs_ddram_bridge
  import gs_ddram_pkg::*;
#(
  parameter logic [28:0] BASE = 29'h0600000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [20:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        rd,
  input  logic        wr,
  output logic        ready,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);

  gs_st_t              state;
  logic                prev_req;
  logic [20:0]         last_addr;
  logic                req;
  logic                accept;
  logic                hit;
  logic [7:0]          hit_byte;
  logic [7:0]          fill_byte;
  logic [28:0]         qword_addr;
  logic [GS_TAG_W-1:0] cur_tag;

  assign req        = rd | wr;
  assign cur_tag    = addr[20:3];
  assign qword_addr = BASE + {8'd0, cur_tag};
  assign fill_byte  = DDRAM_DOUT[{last_addr[2:0], 3'b000} +: 8];

  // A held strobe is a new access only if it just rose or the address moved.
  assign accept = (state == IDLE) && req && (!prev_req || (addr != last_addr));

  assign DDRAM_BURSTCNT = 8'd1;

  gs_line_cache u_cache (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .lookup_tag  (cur_tag),
    .lookup_lane (addr[2:0]),
    .hit         (hit),
    .lookup_byte (hit_byte),
    .load_en     ((state == RD_WAIT) && DDRAM_DOUT_READY),
    .load_line   (DDRAM_DOUT),
    .load_tag    (last_addr[20:3]),
    .patch_en    (accept && wr && hit),
    .patch_lane  (addr[2:0]),
    .patch_data  (din)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      prev_req   <= 1'b0;
      last_addr  <= 21'd0;
      ready      <= 1'b1;
      dout       <= 8'hFF;
      DDRAM_RD   <= 1'b0;
      DDRAM_WE   <= 1'b0;
      DDRAM_ADDR <= BASE;
      DDRAM_DIN  <= 64'd0;
      DDRAM_BE   <= 8'd0;
    end else begin
      prev_req <= req;
      case (state)
        IDLE: begin
          if (accept) begin
            last_addr <= addr;
            // Write takes priority when both strobes are up.
            if (wr) begin
              state      <= WR_REQ;
              ready      <= 1'b0;
              DDRAM_WE   <= 1'b1;
              DDRAM_ADDR <= qword_addr;
              DDRAM_DIN  <= {8{din}};
              DDRAM_BE   <= lane_be(addr[2:0]);
            end else if (hit) begin
              dout <= hit_byte;
            end else begin
              state      <= RD_REQ;
              ready      <= 1'b0;
              DDRAM_RD   <= 1'b1;
              DDRAM_ADDR <= qword_addr;
            end
          end
        end
        RD_REQ: begin
          if (!DDRAM_BUSY) begin
            DDRAM_RD <= 1'b0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (DDRAM_DOUT_READY) begin
            dout  <= fill_byte;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        WR_REQ: begin
          if (!DDRAM_BUSY) begin
            DDRAM_WE <= 1'b0;
            ready    <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gs_ddram_bridge.sv
// Directed self-checking bench for gs_ddram_bridge.
module tb_gs_ddram_bridge;

  localparam logic [28:0] BASE = 29'h0600000;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [20:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd;
  logic        wr;
  logic        ready;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;

  int n_cmp  = 0;
  int n_fail = 0;
  int overlap = 0;

  gs_ddram_bridge #(.BASE(BASE)) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .addr             (addr),
    .din              (din),
    .dout             (dout),
    .rd               (rd),
    .wr               (wr),
    .ready            (ready),
    .DDRAM_BUSY       (DDRAM_BUSY),
    .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
    .DDRAM_ADDR       (DDRAM_ADDR),
    .DDRAM_DOUT       (DDRAM_DOUT),
    .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
    .DDRAM_RD         (DDRAM_RD),
    .DDRAM_DIN        (DDRAM_DIN),
    .DDRAM_BE         (DDRAM_BE),
    .DDRAM_WE         (DDRAM_WE)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) if (DDRAM_RD && DDRAM_WE) overlap++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task test_reset;
    reset_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
    DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
    repeat (2) @(negedge clk_sys);
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
    n_cmp++; if (dout !== 8'hFF) begin n_fail++; $display("[TB] FAIL reset_dout: got %h expected ff", dout); end
    n_cmp++; if ({DDRAM_RD, DDRAM_WE} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_cmds: got %b%b expected 00", DDRAM_RD, DDRAM_WE); end
    n_cmp++; if (DDRAM_BURSTCNT !== 8'd1) begin n_fail++; $display("[TB] FAIL reset_burstcnt: got %h expected 01", DDRAM_BURSTCNT); end
    n_cmp++; if (DDRAM_ADDR !== BASE) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected %h", DDRAM_ADDR, BASE); end
    n_cmp++; if (DDRAM_DIN !== 64'd0 || DDRAM_BE !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_din_be: got %h/%h expected 0/0", DDRAM_DIN, DDRAM_BE); end
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task test_miss_read;
    rd = 1'b1; addr = 21'h000005;
    @(negedge clk_sys);
    n_cmp++; if (DDRAM_RD !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("[TB] FAIL miss_cmd: got rd=%b ready=%b expected rd=1 ready=0", DDRAM_RD, ready); end
    n_cmp++; if (DDRAM_ADDR !== BASE) begin n_fail++; $display("[TB] FAIL miss_addr: got %h expected %h", DDRAM_ADDR, BASE); end
    @(negedge clk_sys);
    n_cmp++; if (DDRAM_RD !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("[TB] FAIL miss_pulse: got rd=%b ready=%b expected rd=0 ready=0", DDRAM_RD, ready); end
    DDRAM_DOUT = 64'h8877665544332211; DDRAM_DOUT_READY = 1'b1;
    @(negedge clk_sys);
    DDRAM_DOUT_READY = 1'b0;
    n_cmp++; if (ready !== 1'b1 || dout !== 8'h66) begin n_fail++; $display("[TB] FAIL miss_data: got ready=%b dout=%h expected ready=1 dout=66", ready, dout); end
    rd = 1'b0;
    @(negedge clk_sys);
  endtask

  task test_hit_read;
    rd = 1'b1; addr = 21'h000007;
    @(negedge clk_sys);
    n_cmp++; if (dout !== 8'h88) begin n_fail++; $display("[TB] FAIL hit_dout: got %h expected 88", dout); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ready !== 1'b1 || DDRAM_RD !== 1'b0) begin n_fail++; $display("[TB] FAIL hit_no_ddr: got ready=%b rd=%b expected ready=1 rd=0", ready, DDRAM_RD); end
      @(negedge clk_sys);
    end
    rd = 1'b0;
    @(negedge clk_sys);
  endtask

  task test_write_busy;
    int we_cycles;
    bit done;
    we_cycles = 0; done = 1'b0;
    DDRAM_BUSY = 1'b1; wr = 1'b1; din = 8'hAB; addr = 21'h000002;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk_sys);
      if (DDRAM_WE) begin
        we_cycles++;
        n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_ready_low: got %b expected 0", ready); end
        if (we_cycles == 1) begin
          n_cmp++; if (DDRAM_BE !== 8'h04) begin n_fail++; $display("[TB] FAIL wr_be: got %h expected 04", DDRAM_BE); end
          n_cmp++; if (DDRAM_DIN !== 64'hABABABABABABABAB) begin n_fail++; $display("[TB] FAIL wr_din: got %h expected abababababababab", DDRAM_DIN); end
          n_cmp++; if (DDRAM_ADDR !== BASE) begin n_fail++; $display("[TB] FAIL wr_addr: got %h expected %h", DDRAM_ADDR, BASE); end
        end
        if (we_cycles == 6) DDRAM_BUSY = 1'b0;
      end else if (we_cycles > 0) begin
        done = 1'b1;
      end
    end
    n_cmp++; if (done !== 1'b1 || we_cycles != 6) begin n_fail++; $display("[TB] FAIL wr_we_cycles: got %0d (done=%b) expected 6", we_cycles, done); end
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_ready_rise: got %b expected 1", ready); end
    DDRAM_BUSY = 1'b0; wr = 1'b0;
    @(negedge clk_sys);
    rd = 1'b1; addr = 21'h000002;
    @(negedge clk_sys);
    n_cmp++; if (dout !== 8'hAB || ready !== 1'b1 || DDRAM_RD !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_patch_hit: got dout=%h ready=%b rd=%b expected ab/1/0", dout, ready, DDRAM_RD); end
    rd = 1'b0;
    @(negedge clk_sys);
  endtask

  task test_rd_wr_together;
    rd = 1'b1; wr = 1'b1; din = 8'h5A; addr = 21'h1FFFF8;
    @(negedge clk_sys);
    n_cmp++; if (DDRAM_WE !== 1'b1 || DDRAM_RD !== 1'b0) begin n_fail++; $display("[TB] FAIL both_write_only: got we=%b rd=%b expected we=1 rd=0", DDRAM_WE, DDRAM_RD); end
    n_cmp++; if (DDRAM_ADDR !== 29'h063FFFF) begin n_fail++; $display("[TB] FAIL both_wrap_addr: got %h expected 063ffff", DDRAM_ADDR); end
    n_cmp++; if (DDRAM_BE !== 8'h01) begin n_fail++; $display("[TB] FAIL both_be: got %h expected 01", DDRAM_BE); end
    @(negedge clk_sys);
    n_cmp++; if (DDRAM_WE !== 1'b0 || DDRAM_RD !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("[TB] FAIL both_done: got we=%b rd=%b ready=%b expected 0/0/1", DDRAM_WE, DDRAM_RD, ready); end
    rd = 1'b0; wr = 1'b0;
    @(negedge clk_sys);
  endtask

  task test_reset_mid_read;
    rd = 1'b1; addr = 21'h000040;
    @(negedge clk_sys);
    @(negedge clk_sys);
    n_cmp++; if (DDRAM_RD !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_in_wait: got rd=%b ready=%b expected 0/0", DDRAM_RD, ready); end
    reset_n = 1'b0; rd = 1'b0;
    @(negedge clk_sys);
    n_cmp++; if (ready !== 1'b1 || dout !== 8'hFF) begin n_fail++; $display("[TB] FAIL rst_mid_state: got ready=%b dout=%h expected 1/ff", ready, dout); end
    reset_n = 1'b1;
    DDRAM_DOUT = 64'h1122334455667788; DDRAM_DOUT_READY = 1'b1;
    @(negedge clk_sys);
    DDRAM_DOUT_READY = 1'b0;
    n_cmp++; if (ready !== 1'b1 || dout !== 8'hFF) begin n_fail++; $display("[TB] FAIL rst_late_ignored: got ready=%b dout=%h expected 1/ff", ready, dout); end
    rd = 1'b1; addr = 21'h000040;
    @(negedge clk_sys);
    n_cmp++; if (DDRAM_RD !== 1'b1 || DDRAM_ADDR !== 29'h0600008) begin n_fail++; $display("[TB] FAIL rst_fresh_read: got rd=%b addr=%h expected 1/0600008", DDRAM_RD, DDRAM_ADDR); end
    @(negedge clk_sys);
    DDRAM_DOUT = 64'hFEDCBA9876543210; DDRAM_DOUT_READY = 1'b1;
    @(negedge clk_sys);
    DDRAM_DOUT_READY = 1'b0;
    n_cmp++; if (ready !== 1'b1 || dout !== 8'h10) begin n_fail++; $display("[TB] FAIL rst_refill: got ready=%b dout=%h expected 1/10", ready, dout); end
    rd = 1'b0;
    @(negedge clk_sys);
  endtask

  task test_addr_change;
    DDRAM_BUSY = 1'b1; rd = 1'b1; addr = 21'h000010;
    @(negedge clk_sys);
    n_cmp++; if (DDRAM_RD !== 1'b1 || DDRAM_ADDR !== 29'h0600002) begin n_fail++; $display("[TB] FAIL chg_first_cmd: got rd=%b addr=%h expected 1/0600002", DDRAM_RD, DDRAM_ADDR); end
    @(negedge clk_sys);
    n_cmp++; if (DDRAM_RD !== 1'b1) begin n_fail++; $display("[TB] FAIL chg_busy_hold: got %b expected 1", DDRAM_RD); end
    DDRAM_BUSY = 1'b0;
    @(negedge clk_sys);
    n_cmp++; if (DDRAM_RD !== 1'b0) begin n_fail++; $display("[TB] FAIL chg_busy_release: got %b expected 0", DDRAM_RD); end
    DDRAM_DOUT = 64'h0123456789ABCDEF; DDRAM_DOUT_READY = 1'b1;
    @(negedge clk_sys);
    DDRAM_DOUT_READY = 1'b0;
    n_cmp++; if (ready !== 1'b1 || dout !== 8'hEF) begin n_fail++; $display("[TB] FAIL chg_first_data: got ready=%b dout=%h expected 1/ef", ready, dout); end
    @(negedge clk_sys);
    n_cmp++; if (DDRAM_RD !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("[TB] FAIL chg_held_no_reaccept: got rd=%b ready=%b expected 0/1", DDRAM_RD, ready); end
    addr = 21'h000020;
    @(negedge clk_sys);
    n_cmp++; if (DDRAM_RD !== 1'b1 || DDRAM_ADDR !== 29'h0600004 || ready !== 1'b0) begin n_fail++; $display("[TB] FAIL chg_second_cmd: got rd=%b addr=%h ready=%b expected 1/0600004/0", DDRAM_RD, DDRAM_ADDR, ready); end
    @(negedge clk_sys);
    DDRAM_DOUT = 64'h00000000000000C3; DDRAM_DOUT_READY = 1'b1;
    @(negedge clk_sys);
    DDRAM_DOUT_READY = 1'b0;
    n_cmp++; if (ready !== 1'b1 || dout !== 8'hC3) begin n_fail++; $display("[TB] FAIL chg_second_data: got ready=%b dout=%h expected 1/c3", ready, dout); end
    rd = 1'b0;
    @(negedge clk_sys);
  endtask

  initial begin
    test_reset();
    test_miss_read();
    test_hit_read();
    test_write_busy();
    test_rd_wr_together();
    test_reset_mid_read();
    test_addr_change();
    n_cmp++; if (overlap != 0) begin n_fail++; $display("[TB] FAIL rd_we_overlap: got %0d cycles expected 0", overlap); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
